// File: rtl/dcache_load_aligner.sv
// rtl/dcache_load_aligner.sv - in-order load-return buffer with byte/halfword alignment and extension
module dcache_load_aligner #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_mem_sel,
  input  logic [4:0]  req_rd,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_fault,
  output logic        resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  resp_ptr_q, resp_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  pending_q, pending_d;
  logic [DEPTH-1:0] ok_q, ok_d;
  logic           resp_err_q, resp_err_d;

  logic [2:0]  f3_q   [DEPTH];
  logic [1:0]  sel_q  [DEPTH];
  logic [4:0]  rd_q   [DEPTH];
  logic [31:0] data_q [DEPTH];

  logic accept, resp_hit, pop;

  function automatic logic [31:0] align_data(input logic [2:0] f3, input logic [1:0] sel,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{sel, 3'b000} +: 8];
    h = w[{sel[1], 4'b0000} +: 16];
    case (f3)
      F3_LB:   align_data = {{24{b[7]}}, b};
      F3_LBU:  align_data = {24'd0, b};
      F3_LH:   align_data = {{16{h[15]}}, h};
      F3_LHU:  align_data = {16'd0, h};
      F3_LW:   align_data = w;
      default: align_data = 32'd0;
    endcase
  endfunction

  // Halfword faults ignore sel[1]; the data path still honours it.
  function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] sel);
    case (f3)
      F3_LB, F3_LBU: load_fault = 1'b0;
      F3_LH, F3_LHU: load_fault = sel[0];
      F3_LW:         load_fault = (sel != 2'd0);
      default:       load_fault = 1'b1;
    endcase
  endfunction

  assign req_ready = (count_q < FULL);
  assign out_valid = ok_q[rd_ptr_q] && (count_q != '0);
  assign out_rdata = out_valid ? data_q[rd_ptr_q] : 32'd0;
  assign out_rd    = out_valid ? rd_q[rd_ptr_q] : 5'd0;
  assign out_fault = out_valid ? load_fault(f3_q[rd_ptr_q], sel_q[rd_ptr_q]) : 1'b0;
  assign resp_err  = resp_err_q;

  // pending_q is registered, so a same-cycle accept can never absorb this response.
  assign accept   = req_valid && req_ready;
  assign resp_hit = mem_resp && (pending_q != '0);
  assign pop      = out_valid && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    resp_ptr_d = resp_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ok_d       = ok_q;
    resp_err_d = resp_err_q | (mem_resp && (pending_q == '0));
    count_d    = count_q + CW'(accept) - CW'(pop);
    pending_d  = pending_q + CW'(accept) - CW'(resp_hit);
    if (accept) begin
      ok_d[wr_ptr_q] = 1'b0;
      wr_ptr_d       = wr_ptr_q + PW'(1);
    end
    if (resp_hit) begin
      ok_d[resp_ptr_q] = 1'b1;
      resp_ptr_d       = resp_ptr_q + PW'(1);
    end
    if (pop) begin
      ok_d[rd_ptr_q] = 1'b0;
      rd_ptr_d       = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      resp_ptr_q <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      ok_q       <= '0;
      resp_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      resp_ptr_q <= resp_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      ok_q       <= ok_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Slot payload needs no reset: ok_q gates every use of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q[wr_ptr_q]  <= req_funct3;
      sel_q[wr_ptr_q] <= req_mem_sel;
      rd_q[wr_ptr_q]  <= req_rd;
    end
    if (resp_hit) begin
      data_q[resp_ptr_q] <= align_data(f3_q[resp_ptr_q], sel_q[resp_ptr_q], mem_rdata);
    end
  end

endmodule

// File: tb/tb_dcache_load_aligner.sv
// tb/tb_dcache_load_aligner.sv - directed and random checks of dcache_load_aligner against a queue model
module tb_dcache_load_aligner;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'd0;
  logic [1:0]  req_mem_sel = 2'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_fault;
  logic        resp_err;

  dcache_load_aligner #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_mem_sel(req_mem_sel), .req_rd(req_rd),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_rd(out_rd), .out_fault(out_fault),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] f3; logic [1:0] sel; logic [4:0] rd; } req_t;
  typedef struct { logic [31:0] data; logic [4:0] rd; logic fault; } cpl_t;

  req_t pend[$];
  cpl_t done[$];
  bit   m_err;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_align(input logic [2:0] f3, input logic [1:0] s,
                                    input logic [31:0] w, output logic [31:0] d, output logic f);
    int unsigned b, h, wu;
    wu = w;
    b = (wu / (32'd1 << (8 * s))) % 256;
    h = (wu / (32'd1 << (16 * s[1]))) % 65536;
    case (f3)
      3'd0:    begin d = (b >= 128) ? b + 32'hFFFFFF00 : b; f = 1'b0; end
      3'd4:    begin d = b; f = 1'b0; end
      3'd1:    begin d = (h >= 32768) ? h + 32'hFFFF0000 : h; f = (s % 2 == 1); end
      3'd5:    begin d = h; f = (s % 2 == 1); end
      3'd2:    begin d = w; f = (s != 0); end
      default: begin d = 32'd0; f = 1'b1; end
    endcase
  endfunction

  task automatic check_model(input string tag);
    bit v;
    v = done.size() > 0;
    chk({tag, "_valid"}, out_valid, v);
    chk({tag, "_rdata"}, out_rdata, v ? done[0].data : 32'd0);
    chk({tag, "_rd"}, out_rd, v ? done[0].rd : 5'd0);
    chk({tag, "_fault"}, out_fault, v ? done[0].fault : 1'b0);
    chk({tag, "_ready"}, req_ready, (pend.size() + done.size()) < DEPTH);
    chk({tag, "_err"}, resp_err, m_err);
  endtask

  task automatic step(input logic rv, input logic [2:0] f3, input logic [1:0] sel,
                      input logic [4:0] rd, input logic mr, input logic [31:0] w,
                      input logic ordy, input string tag);
    bit acc, rok, pp;
    req_t r;
    cpl_t c;
    req_valid = rv; req_funct3 = f3; req_mem_sel = sel; req_rd = rd;
    mem_resp = mr; mem_rdata = w; out_ready = ordy;
    acc = rv && ((pend.size() + done.size()) < DEPTH);
    rok = mr && (pend.size() > 0);
    pp  = ordy && (done.size() > 0);
    if (mr && !rok) m_err = 1'b1;
    @(posedge clk); #1;
    if (pp) done.delete(0);
    if (rok) begin
      r = pend.pop_front();
      ref_align(r.f3, r.sel, w, c.data, c.fault);
      c.rd = r.rd;
      done.push_back(c);
    end
    if (acc) begin
      r.f3 = f3; r.sel = sel; r.rd = rd;
      pend.push_back(r);
    end
    req_valid = 1'b0; mem_resp = 1'b0; out_ready = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset();
    req_valid = 1'b0; mem_resp = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    pend.delete(); done.delete(); m_err = 1'b0;
    #1;
    check_model("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic one_load(input logic [2:0] f3, input logic [1:0] sel, input logic [4:0] rd,
                          input logic [31:0] w, input logic [31:0] exp_d, input logic exp_f,
                          input string tag);
    step(1'b1, f3, sel, rd, 1'b0, 32'd0, 1'b0, {tag, "_req"});
    step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, w, 1'b0, {tag, "_resp"});
    chk({tag, "_c_valid"}, out_valid, 1'b1);
    chk({tag, "_c_data"}, out_rdata, exp_d);
    chk({tag, "_c_fault"}, out_fault, exp_f);
    chk({tag, "_c_rd"}, out_rd, rd);
    step(1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 32'd0, 1'b1, {tag, "_pop"});
  endtask

  initial begin
    m_err = 1'b0;
    do_reset();
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);

    one_load(3'd0, 2'd2, 5'd7, 32'h12803456, 32'hFFFFFF80, 1'b0, "lb");
    one_load(3'd4, 2'd2, 5'd8, 32'h12803456, 32'h00000080, 1'b0, "lbu");
    one_load(3'd1, 2'd2, 5'd9, 32'h80017FFF, 32'hFFFF8001, 1'b0, "lh");
    one_load(3'd5, 2'd2, 5'd10, 32'h80017FFF, 32'h00008001, 1'b0, "lhu");
    one_load(3'd1, 2'd0, 5'd11, 32'h80017FFF, 32'h00007FFF, 1'b0, "lh0");
    one_load(3'd5, 2'd3, 5'd12, 32'h80017FFF, 32'h00008001, 1'b1, "lhu_mis");
    one_load(3'd2, 2'd1, 5'd13, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, "lw_mis");
    one_load(3'd3, 2'd0, 5'd14, 32'hDEADBEEF, 32'h00000000, 1'b1, "f3_bad");

    for (int k = 1; k <= 4; k++) step(1'b1, 3'd2, 2'd0, 5'(k), 1'b0, 32'd0, 1'b0, "fill");
    chk("full_ready", req_ready, 1'b0);
    step(1'b1, 3'd2, 2'd0, 5'd30, 1'b0, 32'd0, 1'b0, "full_reject");
    for (int k = 1; k <= 4; k++) step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h100 + k, 1'b0, "fill_resp");
    chk("full_head_rd", out_rd, 5'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_rd", out_rd, 5'(k));
      step(1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 32'd0, 1'b1, "drain");
      if (k == 1) chk("ready_after_pop", req_ready, 1'b1);
    end
    chk("drain_empty", out_valid, 1'b0);

    step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h55, 1'b0, "spurious");
    chk("spur_err", resp_err, 1'b1);
    step(1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 32'd0, 1'b0, "spur_hold");
    chk("spur_err_hold", resp_err, 1'b1);
    chk("spur_no_valid", out_valid, 1'b0);
    do_reset();
    chk("err_cleared", resp_err, 1'b0);

    step(1'b1, 3'd2, 2'd0, 5'd3, 1'b0, 32'd0, 1'b0, "mid_a");
    step(1'b1, 3'd0, 2'd1, 5'd4, 1'b1, 32'hA5A5A5A5, 1'b0, "mid_b");
    do_reset();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    step(1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h77, 1'b0, "late_resp");
    chk("late_err", resp_err, 1'b1);
    one_load(3'd2, 2'd0, 5'd21, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, "post_rst_lw");

    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), ($urandom_range(0, 2) != 0) && (pend.size() > 0),
           $urandom, $urandom_range(0, 3) != 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
